// File: rtl/score_display.sv
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module   : score_display                                                   |
// | Purpose  : Latches one of NUM_CH source channels on request and drives     |
// |            NUM_DIGITS active-low seven-segment digits in hex or decimal.   |
// |            Decimal uses an iterative double-dabble, one shift per cycle.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   i_clk       rising-edge system clock                                     |
// |   i_rst_n     asynchronous active-low reset                                |
// |   i_ch_data   packed sources, channel i at [i*DATA_WIDTH +: DATA_WIDTH]    |
// |   i_ch_sel    source channel index (out of range selects channel 0)        |
// |   i_mode_dec  1 = decimal, 0 = hex (sampled at conversion start)           |
// |   i_update    single-cycle refresh request                                 |
// |   o_seg       active-low segments, digit d at [7*d +: 7], bit0=a..bit6=g   |
// |   o_busy      conversion in progress                                       |
// |   o_done      one-cycle pulse when o_seg is updated                        |
// |   o_overflow  displayed value does not fit NUM_DIGITS digits               |
// +----------------------------------------------------------------------------+
// | Build option                                                               |
// |   SCORE_DISPLAY_LZB_EN  blank leading zero digits (digit 0 always shown,   |
// |                         not applied while overflow is shown)               |
// +----------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module score_display #(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  localparam int CSW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_ch_data,
  input  logic [CSW-1:0]               i_ch_sel,
  input  logic                         i_mode_dec,
  input  logic                         i_update,
  output logic [7*NUM_DIGITS-1:0]      o_seg,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_overflow
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int EXT_W = (DATA_WIDTH > BCD_W) ? DATA_WIDTH : BCD_W;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [6:0] c_BLANK = 7'b1111111;
  localparam logic [6:0] c_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_value;    // latched source; doubles as shift register in decimal mode
  logic                    r_mode;
  logic [BCD_W-1:0]        r_bcd;
  logic                    r_bcd_ovf;  // sticky carry out of the top BCD digit
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_pending;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_ovf;
  logic [7*NUM_DIGITS-1:0] r_seg;

  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic [BCD_W-1:0]        w_bcd_adj;
  logic [BCD_W-1:0]        w_bcd_next;
  logic                    w_bcd_carry;
  logic [EXT_W-1:0]        w_value_ext;
  logic                    w_hex_ovf;
  logic                    w_ovf_new;
  logic [7*NUM_DIGITS-1:0] w_seg_new;
  logic [3:0]              w_nib;
  logic                    w_start;
`ifdef SCORE_DISPLAY_LZB_EN
  logic                    w_seen;
`endif

  function automatic logic [6:0] f_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: f_glyph = 7'b1000000;
      4'h1: f_glyph = 7'b1111001;
      4'h2: f_glyph = 7'b0100100;
      4'h3: f_glyph = 7'b0110000;
      4'h4: f_glyph = 7'b0011001;
      4'h5: f_glyph = 7'b0010010;
      4'h6: f_glyph = 7'b0000010;
      4'h7: f_glyph = 7'b1111000;
      4'h8: f_glyph = 7'b0000000;
      4'h9: f_glyph = 7'b0010000;
      4'hA: f_glyph = 7'b0001000;
      4'hB: f_glyph = 7'b0000011;
      4'hC: f_glyph = 7'b1000110;
      4'hD: f_glyph = 7'b0100001;
      4'hE: f_glyph = 7'b0000110;
      default: f_glyph = 7'b0001110;
    endcase
  endfunction

  // Source mux; any index without a matching channel falls back to channel 0.
  always_comb begin
    w_sel_data = i_ch_data[0 +: DATA_WIDTH];
    for (int i = 1; i < NUM_CH; i++) begin
      if (i_ch_sel == CSW'(i)) begin
        w_sel_data = i_ch_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Double-dabble step: add 3 to every digit >= 5, then shift the next source bit in.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  assign w_bcd_next  = {w_bcd_adj[BCD_W-2:0], r_value[DATA_WIDTH-1]};
  // A set MSB after adjustment means doubling crosses 10^NUM_DIGITS.
  assign w_bcd_carry = w_bcd_adj[BCD_W-1];

  assign w_value_ext = EXT_W'(r_value);
  assign w_hex_ovf   = |(w_value_ext >> BCD_W);

  // Glyph generation for the commit cycle, scanning from the top digit down so
  // leading-zero blanking can track whether a nonzero digit has been seen.
  always_comb begin
    w_ovf_new = r_mode ? r_bcd_ovf : w_hex_ovf;
    w_seg_new = '1;
    w_nib     = 4'd0;
`ifdef SCORE_DISPLAY_LZB_EN
    w_seen    = 1'b0;
`endif
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      w_nib = r_mode ? r_bcd[4*d +: 4] : w_value_ext[4*d +: 4];
`ifdef SCORE_DISPLAY_LZB_EN
      w_seen = w_seen | (w_nib != 4'd0) | (d == 0);
      if (w_ovf_new) begin
        w_seg_new[7*d +: 7] = c_DASH;
      end else if (!w_seen) begin
        w_seg_new[7*d +: 7] = c_BLANK;
      end else begin
        w_seg_new[7*d +: 7] = f_glyph(w_nib);
      end
`else
      if (w_ovf_new) begin
        w_seg_new[7*d +: 7] = c_DASH;
      end else begin
        w_seg_new[7*d +: 7] = f_glyph(w_nib);
      end
`endif
    end
  end

  // A new conversion starts from IDLE on a request, or straight out of COMMIT
  // when a request is pending or arrives during COMMIT itself.
  assign w_start = ((r_state == IDLE) && i_update) ||
                   ((r_state == COMMIT) && (r_pending || i_update));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_value   <= '0;
      r_mode    <= 1'b0;
      r_bcd     <= '0;
      r_bcd_ovf <= 1'b0;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_seg     <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
        end
        CONVERT: begin
          if (i_update) begin
            r_pending <= 1'b1;
          end
          r_bcd     <= w_bcd_next;
          r_bcd_ovf <= r_bcd_ovf | w_bcd_carry;
          r_value   <= r_value << 1;
          r_cnt     <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            r_state <= COMMIT;
          end
        end
        COMMIT: begin
          r_seg     <= w_seg_new;
          r_ovf     <= w_ovf_new;
          r_done    <= 1'b1;
          r_pending <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_start) begin
        r_value   <= w_sel_data;
        r_mode    <= i_mode_dec;
        r_bcd     <= '0;
        r_bcd_ovf <= 1'b0;
        r_cnt     <= '0;
        r_busy    <= 1'b1;
        r_state   <= i_mode_dec ? CONVERT : COMMIT;
      end
    end
  end

  assign o_seg      = r_seg;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_score_display.sv
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module   : tb_score_display                                                |
// | Purpose  : Scoreboard bench for score_display (6 digits, 32-bit, 4 ch).    |
// |            Stimulus pushes expected seg/overflow/done-cycle; a monitor    |
// |            pops and compares on every done pulse.                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_score_display;

  localparam int ND  = 6;
  localparam int DW  = 32;
  localparam int NC  = 4;
  localparam int CSW = 2;
  localparam int BL  = 16;
  localparam int DS  = 17;
`ifdef SCORE_DISPLAY_LZB_EN
  localparam int LZ  = BL;
`else
  localparam int LZ  = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DW-1:0]     ch [NC];
  logic [NC*DW-1:0]  ch_data;
  logic [CSW-1:0]    ch_sel;
  logic              mode_dec;
  logic              update;
  logic [7*ND-1:0]   seg;
  logic              busy;
  logic              done;
  logic              ovf;

  assign ch_data = {ch[3], ch[2], ch[1], ch[0]};

  score_display #(
    .NUM_DIGITS (ND),
    .DATA_WIDTH (DW),
    .NUM_CH     (NC)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ch_data  (ch_data),
    .i_ch_sel   (ch_sel),
    .i_mode_dec (mode_dec),
    .i_update   (update),
    .o_seg      (seg),
    .o_busy     (busy),
    .o_done     (done),
    .o_overflow (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7*ND-1:0] seg;
    logic            ovf;
    int              cyc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   c_raise = 0;

  function automatic logic [6:0] gl(input int n);
    case (n)
      0:  gl = 7'b1000000;
      1:  gl = 7'b1111001;
      2:  gl = 7'b0100100;
      3:  gl = 7'b0110000;
      4:  gl = 7'b0011001;
      5:  gl = 7'b0010010;
      6:  gl = 7'b0000010;
      7:  gl = 7'b1111000;
      8:  gl = 7'b0000000;
      9:  gl = 7'b0010000;
      10: gl = 7'b0001000;
      11: gl = 7'b0000011;
      12: gl = 7'b1000110;
      13: gl = 7'b0100001;
      14: gl = 7'b0000110;
      15: gl = 7'b0001110;
      DS: gl = 7'b0111111;
      default: gl = 7'b1111111;
    endcase
  endfunction

  function automatic logic [7*ND-1:0] mk(input int d5, input int d4, input int d3,
                                          input int d2, input int d1, input int d0);
    mk = {gl(d5), gl(d4), gl(d3), gl(d2), gl(d1), gl(d0)};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        m_e = q.pop_front();
        check("seg", {22'd0, seg}, {22'd0, m_e.seg});
        check("overflow", {63'd0, ovf}, {63'd0, m_e.ovf});
        check("done_cycle", 64'(cyc), 64'(m_e.cyc));
      end
    end
  end

  // Pulse update for one cycle; optionally register the expected result,
  // due `lat` cycles after the sampling edge.
  task automatic issue(input int sel, input logic dec, input logic [7*ND-1:0] es,
                       input logic eo, input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    ch_sel   = CSW'(sel);
    mode_dec = dec;
    update   = 1'b1;
    c_raise  = cyc;
    if (push) begin
      e.seg = es;
      e.ovf = eo;
      e.cyc = cyc + 1 + lat;
      q.push_back(e);
    end
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_idle(output int nbusy);
    int k;
    nbusy = 0;
    k = 0;
    while ((busy || q.size() != 0) && k < 300) begin
      if (busy) nbusy++;
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle_timeout: got busy=%0d pending=%0d, expected idle", busy, q.size());
      q.delete();
    end
  endtask

  initial begin
    int nb;
    int c1;
    int k;
    exp_t e;
    ch[0] = 32'h00001A2F;
    ch[1] = 32'd987654;
    ch[2] = 32'd1000000;
    ch[3] = 32'd42;
    ch_sel = '0;
    mode_dec = 1'b0;
    update = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_seg", {22'd0, seg}, {22'd0, {7*ND{1'b1}}});
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_ovf", {63'd0, ovf}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Hex 1A2F on channel 0, one-cycle latency
    issue(0, 1'b0, mk(LZ, LZ, 1, 10, 2, 15), 1'b0, 1, 1'b1);
    wait_idle(nb);
    check("hex_busy_cycles", 64'(nb), 64'd1);

    // Display holds after source data changes
    ch[0] = 32'h0000FFFF;
    repeat (5) @(negedge clk);
    check("seg_hold", {22'd0, seg}, {22'd0, mk(LZ, LZ, 1, 10, 2, 15)});

    // Decimal 987654 on channel 1, 33 busy cycles
    issue(1, 1'b1, mk(9, 8, 7, 6, 5, 4), 1'b0, 33, 1'b1);
    wait_idle(nb);
    check("dec_busy_cycles", 64'(nb), 64'd33);

    // Decimal 1000000 overflows
    issue(2, 1'b1, mk(DS, DS, DS, DS, DS, DS), 1'b1, 33, 1'b1);
    wait_idle(nb);

    // Decimal 999999 is the largest that fits
    ch[3] = 32'd999999;
    issue(3, 1'b1, mk(9, 9, 9, 9, 9, 9), 1'b0, 33, 1'b1);
    wait_idle(nb);

    // Hex boundary: bit 24 set overflows, 0xFFFFFF fits
    ch[0] = 32'h01000000;
    issue(0, 1'b0, mk(DS, DS, DS, DS, DS, DS), 1'b1, 1, 1'b1);
    wait_idle(nb);
    ch[0] = 32'h00FFFFFF;
    issue(0, 1'b0, mk(15, 15, 15, 15, 15, 15), 1'b0, 1, 1'b1);
    wait_idle(nb);

    // Decimal 0 and 305
    ch[0] = 32'd0;
    issue(0, 1'b1, mk(LZ, LZ, LZ, LZ, LZ, 0), 1'b0, 33, 1'b1);
    wait_idle(nb);
    ch[0] = 32'd305;
    issue(0, 1'b1, mk(LZ, LZ, LZ, 3, 0, 5), 1'b0, 33, 1'b1);
    wait_idle(nb);

    // Pending: second request queued, third dropped
    ch[1] = 32'd987654;
    ch[3] = 32'd42;
    issue(1, 1'b1, mk(9, 8, 7, 6, 5, 4), 1'b0, 33, 1'b1);
    c1 = c_raise;
    repeat (5) @(negedge clk);
    issue(3, 1'b1, '0, 1'b0, 0, 1'b0);
    e.seg = mk(LZ, LZ, LZ, LZ, 4, 2);
    e.ovf = 1'b0;
    e.cyc = c1 + 1 + 66;
    q.push_back(e);
    repeat (5) @(negedge clk);
    issue(3, 1'b1, '0, 1'b0, 0, 1'b0);
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("first_done_seen", {63'd0, done}, 64'd1);
    check("busy_held_after_done", {63'd0, busy}, 64'd1);
    wait_idle(nb);
    check("third_dropped_queue_empty", 64'(q.size()), 64'd0);
    repeat (40) @(negedge clk);

    // Reset at cycle 10 of a decimal conversion
    ch[0] = 32'd123456;
    issue(0, 1'b1, '0, 1'b0, 0, 1'b0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_seg", {22'd0, seg}, {22'd0, {7*ND{1'b1}}});
    check("abort_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_seg_after", {22'd0, seg}, {22'd0, {7*ND{1'b1}}});
    check("abort_busy_after", {63'd0, busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter NUM_DIGITS, default 6, number of seven-segment digits driven.
REQ-002 Parameter DATA_WIDTH, default 32, width of each source channel.
REQ-003 Parameter NUM_CH, default 4, number of selectable source channels; CSW = max(1, clog2(NUM_CH)).
REQ-004 Clock  in  1  rising-edge system clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 ch_data  in  NUM_CH*DATA_WIDTH  packed sources; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 ch_sel  in  CSW  source channel index, sampled at conversion start.
REQ-008 mode_dec  in  1  1 = decimal display, 0 = hex display; sampled at conversion start.
REQ-009 update  in  1  single-cycle request to refresh the display.
REQ-010 seg  out  7*NUM_DIGITS  active-low segments; digit d at [7*d +: 7], digit 0 least significant, bit0 = a through bit6 = g.
REQ-011 busy  out  1  high while a conversion is in progress.
REQ-012 done  out  1  one-cycle pulse when seg is updated.
REQ-013 overflow  out  1  high when the displayed value does not fit NUM_DIGITS digits.

Function
REQ-014 The FSM SHALL have states IDLE, CONVERT and COMMIT.
REQ-015 In IDLE, update high at edge N SHALL latch ch_data[ch_sel] and mode_dec, and go to COMMIT (hex) or CONVERT (decimal).
REQ-016 ch_sel >= NUM_CH SHALL select channel 0.
REQ-017 CONVERT SHALL perform one iterative double-dabble shift per cycle for exactly DATA_WIDTH cycles, then go to COMMIT.
REQ-018 COMMIT SHALL last one cycle, after which seg, overflow and done are registered and the FSM returns to IDLE.
REQ-019 Latency from the update edge N to the first cycle with new seg and done=1 SHALL be 1 cycle (hex) or DATA_WIDTH+1 cycles (decimal).
REQ-020 busy SHALL be high in CONVERT and COMMIT, and low in IDLE.
REQ-021 update while busy SHALL set a one-deep pending flag; further updates while pending SHALL be dropped.
REQ-022 If pending is set at COMMIT, the FSM SHALL start a new conversion on the next edge with freshly sampled ch_sel/mode_dec, keeping busy high and clearing pending.
REQ-023 Hex mode SHALL show value[4*d+3:4*d] on digit d; overflow = 1 if any value bit at or above 4*NUM_DIGITS is 1.
REQ-024 Decimal mode overflow SHALL be 1 iff value > 10^NUM_DIGITS - 1, using a sticky carry out of the top BCD digit.
REQ-025 On overflow, every digit SHALL show a dash, 7'b0111111.
REQ-026 Glyphs SHALL be the standard active-low hex set: 0 = 7'b1000000 … F = 7'b0001110; blank = 7'b1111111.
REQ-027 seg SHALL hold its last committed value between conversions, independent of later ch_data changes.

Reset
REQ-028 reset low SHALL immediately force IDLE, busy=0, done=0, overflow=0, pending=0 and all digits blank (7'b1111111).
REQ-029 reset during CONVERT or COMMIT SHALL abort the conversion with no done pulse and no seg update.

Configuration
REQ-030 Macro SCORE_DISPLAY_LZB_EN defined: leading-zero digits above the most significant nonzero digit SHALL be blanked; digit 0 is always shown; not applied on overflow.
REQ-031 Macro SCORE_DISPLAY_LZB_EN undefined: all NUM_DIGITS digits SHALL be shown, including leading zeros.

Verification (NUM_DIGITS=6, DATA_WIDTH=32, NUM_CH=4, macro undefined unless stated)
REQ-032 ch0=32'h00001A2F, mode_dec=0, update at edge N -> done at N+1; digits 5..0 = 0,0,1,A,2,F; overflow=0.
REQ-033 ch1=32'd987654, mode_dec=1, update -> busy for 33 cycles; done at N+33; digits = 9,8,7,6,5,4.
REQ-034 ch2=32'd1000000, decimal -> overflow=1; all six digits = 7'b0111111.
REQ-035 Decimal update, then update with ch_sel=3 mid-CONVERT, then a third update -> second conversion of ch3 starts right after the first done, busy stays high; third update is dropped; exactly two done pulses.
REQ-036 reset low at cycle 10 of a decimal conversion -> busy=0 and seg all blank at once; no done pulse.
REQ-037 SCORE_DISPLAY_LZB_EN defined, decimal value 0 -> digits 5..1 blank and digit 0 = 7'b1000000; value 305 -> digits 5..3 blank, digits 2..0 = 3,0,5.
